fifo_rd: RTL and testbench
==========================

# fifo_rd

Read-side controller and data checker for the loopback FIFO test on the Kintex-7 board. It waits for the FIFO to report full, drains it in one continuous burst, and checks that each burst contains the expected wrapping sequence (0, 1, …, 254, 0, …). It reports per-burst word counts and mismatch statistics. It sits in the read clock domain, between the FIFO IP read port and the top-level status/ILA probes.

## Interface
- DATA_W, 8, FIFO data width
- WRAP_MAX, 254, last value before the expected sequence wraps to 0
- CNT_W, 10, width of the burst word counter (covers a FIFO depth of up to 1023)

- rd_clk  in  1  read-domain clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- rd_rst_busy  in  1  FIFO read-side reset in progress
- full  in  1  FIFO full flag (write-domain origin, synchronized internally)
- empty  in  1  FIFO empty flag (read domain)
- fifo_rd_data  in  DATA_W  FIFO read data (standard mode: valid one cycle after rd_en)
- fifo_rd_en  out  1  FIFO read enable
- rd_data_vld  out  1  fifo_rd_data holds a valid word this cycle
- rd_data  out  DATA_W  pass-through of fifo_rd_data
- burst_done  out  1  one-cycle pulse at the end of each drain burst
- burst_len  out  CNT_W  number of words read in the last completed burst
- burst_cnt  out  16  completed bursts, wraps at 2^16
- err  out  1  sticky; set on the first data mismatch
- err_cnt  out  16  mismatch count, saturates at 0xFFFF

## Operation
- Full sync: full_d0 <= full and full_d1 <= full_d0 on every clock. Only full_d1 is used.
- State machine, three states: IDLE, READ, DONE.
  - IDLE: fifo_rd_en is 0. If full_d1 = 1 and rd_rst_busy = 0, go to READ, clear the word counter, and load the expected value with 0.
  - READ: fifo_rd_en = !empty, decoded combinationally from the state register and the empty input. Each cycle with fifo_rd_en = 1 increments the word counter. If empty = 1, go to DONE.
  - DONE: lasts exactly one cycle. Register burst_len from the word counter, pulse burst_done, increment burst_cnt, then return to IDLE.
- The word counter increments while fifo_rd_en = 1 and does not wrap within a burst; the FIFO depth is below 2^CNT_W.
- rd_rst_busy = 1 in any state forces the FSM to IDLE on the next edge.
  - fifo_rd_en is 0 combinationally.
  - The burst is discarded: no burst_done pulse, and burst_len, burst_cnt and the checker counters are unchanged.
- rd_data_vld is a register that samples fifo_rd_en. rd_data = fifo_rd_data.
- Checker, active when rd_data_vld = 1:
  - If rd_data != expected, set err and increment err_cnt with saturation.
  - Expected always advances: expected = (expected == WRAP_MAX) ? 0 : expected + 1.
  - There is no resync to the received value, so one corrupted word produces exactly one error.
- Reset values: all outputs are 0, the FSM is in IDLE, and the sync flops and the expected value are 0.

## Timing
- If full rises before edge n, full_d1 = 1 after edge n+1, the FSM enters READ at edge n+2, and the first fifo_rd_en is high in the following cycle (3-cycle sync latency).
- Read latency: the word read by fifo_rd_en in cycle k appears with rd_data_vld = 1 in cycle k+1.
- Last read: empty rises after the edge that consumes the final word, so fifo_rd_en drops in the same cycle. Because rd_en is qualified combinationally, no underflow read is ever issued.
- rd_data_vld for the final word coincides with the first READ cycle in which empty = 1.
- The FSM is in DONE in the following cycle. burst_done, burst_len and burst_cnt update at the end of that cycle, one cycle after the last rd_data_vld.
- Entering READ with empty already 1: burst_len = 0 and burst_done still pulses.
- err is set one edge after the mismatching rd_data_vld cycle; err_cnt updates on the same edge.
- Asserting rst_n low mid-burst clears everything asynchronously. After rst_n is released, no read is issued until full_d1 = 1 is seen again.

## Test plan
- FIFO model of depth 256 preloaded with 0..254, 0 and full asserted: first rd_en 3 cycles after full; 256 consecutive reads; burst_len = 256, burst_done pulses once, burst_cnt = 1, err = 0.
- Same burst with word 5 corrupted to 9: exactly one error, err rises one cycle after that word, err_cnt = 1, and later words pass.
- Two back-to-back full/drain cycles, each starting at 0: burst_cnt = 2, err = 0. Second burst starting at 7 instead: err_cnt = 256, because every word of that burst misses the expected value.
- rd_rst_busy pulsed for 4 cycles mid-burst after 100 reads: fifo_rd_en drops the same cycle; FSM in IDLE; no burst_done; burst_cnt unchanged.
- rst_n asserted mid-burst: all outputs are 0 immediately. After release with full held at 1, reads restart 3 cycles later and the expected value restarts at 0.
- Full asserted while empty is also 1 (forced): FSM goes READ, then DONE; burst_len = 0; burst_done pulses; fifo_rd_en never asserts.

Source files
------------

// File: rtl/fifo_rd.sv
// fifo_rd: drains the loopback FIFO once it reports full and checks
// every burst against the wrapping 0..WRAP_MAX sequence.
module fifo_rd #(
   parameter int DATA_W   = 8,
   parameter int WRAP_MAX = 254,
   parameter int CNT_W    = 10
) (
   input  logic              rd_clk,
   input  logic              rst_n,
   input  logic              rd_rst_busy,
   input  logic              full,
   input  logic              empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic              rd_data_vld,
   output logic [DATA_W-1:0] rd_data,
   output logic              burst_done,
   output logic [CNT_W-1:0]  burst_len,
   output logic [15:0]       burst_cnt,
   output logic              err,
   output logic [15:0]       err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] WRAP_V = DATA_W'(WRAP_MAX);
   localparam logic [15:0]       SAT_V  = 16'hFFFF;

   state_t            state_q;
   state_t            state_d;
   logic              full_d0_q;
   logic              full_d1_q;
   logic              rd_en;
   logic              start;
   logic [CNT_W-1:0]  wcnt_q;
   logic [CNT_W-1:0]  wcnt_d;
   logic              vld_q;
   logic [DATA_W-1:0] exp_q;
   logic [DATA_W-1:0] exp_d;
   logic              chk;
   logic              miss;
   logic              done_q;
   logic              done_d;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  len_d;
   logic [15:0]       bcnt_q;
   logic [15:0]       bcnt_d;
   logic              err_q;
   logic              err_d;
   logic [15:0]       ecnt_q;
   logic [15:0]       ecnt_d;

   // two-flop synchronizer for the write-domain full flag
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         full_d0_q <= 1'b0;
         full_d1_q <= 1'b0;
      end else begin
         full_d0_q <= full;
         full_d1_q <= full_d0_q;
      end
   end

   // next state and read enable; FIFO reset overrides every state
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (full_d1_q) begin
               state_d = READ;
               start   = 1'b1;
            end
         end
         READ: begin
            rd_en = !empty;
            if (empty) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rd_rst_busy) begin
         state_d = IDLE;
         rd_en   = 1'b0;
         start   = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // burst word counter, cleared when a drain starts
   always_comb begin
      wcnt_d = wcnt_q;
      if (start) begin
         wcnt_d = '0;
      end else if (rd_en) begin
         wcnt_d = wcnt_q + CNT_W'(1);
      end
   end

   // checker: expected value free-runs, no resync on a bad word
   always_comb begin
      chk    = vld_q && !rd_rst_busy;
      miss   = chk && (fifo_rd_data != exp_q);
      exp_d  = exp_q;
      err_d  = err_q | miss;
      ecnt_d = ecnt_q;
      if (start) begin
         exp_d = '0;
      end else if (chk) begin
         exp_d = (exp_q == WRAP_V) ? '0 : exp_q + DATA_W'(1);
      end
      if (miss && (ecnt_q != SAT_V)) begin
         ecnt_d = ecnt_q + 16'd1;
      end
   end

   // burst record, committed only when DONE is left normally
   always_comb begin
      done_d = (state_q == DONE) && !rd_rst_busy;
      len_d  = len_q;
      bcnt_d = bcnt_q;
      if (done_d) begin
         len_d  = wcnt_q;
         bcnt_d = bcnt_q + 16'd1;
      end
   end

   // datapath registers
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q <= '0;
         vld_q  <= 1'b0;
         exp_q  <= '0;
         err_q  <= 1'b0;
         ecnt_q <= '0;
         done_q <= 1'b0;
         len_q  <= '0;
         bcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         vld_q  <= rd_en;
         exp_q  <= exp_d;
         err_q  <= err_d;
         ecnt_q <= ecnt_d;
         done_q <= done_d;
         len_q  <= len_d;
         bcnt_q <= bcnt_d;
      end
   end

   assign fifo_rd_en  = rd_en;
   assign rd_data_vld = vld_q;
   assign rd_data     = fifo_rd_data;
   assign burst_done  = done_q;
   assign burst_len   = len_q;
   assign burst_cnt   = bcnt_q;
   assign err         = err_q;
   assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_fifo_rd.sv
// tb_fifo_rd: 256-deep FIFO model feeding fifo_rd; scoreboards for
// read words and burst records plus directed timing steps.
module tb_fifo_rd;
   localparam int DW    = 8;
   localparam int CW    = 10;
   localparam int DEPTH = 256;

   logic          rd_clk      = 1'b0;
   logic          rst_n       = 1'b0;
   logic          rd_rst_busy = 1'b0;
   logic          full;
   logic          empty;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_rd_en;
   logic          rd_data_vld;
   logic [DW-1:0] rd_data;
   logic          burst_done;
   logic [CW-1:0] burst_len;
   logic [15:0]   burst_cnt;
   logic          err;
   logic [15:0]   err_cnt;

   logic       force_full = 1'b0;
   logic       ld_req     = 1'b0;
   logic       fl_req     = 1'b0;
   logic [7:0] ld_start   = '0;
   logic [7:0] ld_bad_val = '0;
   int         ld_bad_idx = -1;
   int         fcnt       = 0;
   logic [7:0] w_v;
   logic [7:0] mem_q[$];
   logic [7:0] sb_w[$];
   int         sb_len[$];
   int         sb_cnt[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       mon_on  = 1'b0;

   fifo_rd #(
      .DATA_W  (DW),
      .WRAP_MAX(254),
      .CNT_W   (CW)
   ) dut (
      .rd_clk      (rd_clk),
      .rst_n       (rst_n),
      .rd_rst_busy (rd_rst_busy),
      .full        (full),
      .empty       (empty),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en  (fifo_rd_en),
      .rd_data_vld (rd_data_vld),
      .rd_data     (rd_data),
      .burst_done  (burst_done),
      .burst_len   (burst_len),
      .burst_cnt   (burst_cnt),
      .err         (err),
      .err_cnt     (err_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   assign full  = force_full | (fcnt == DEPTH);
   assign empty = (fcnt == 0);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // standard-mode FIFO: data valid one cycle after rd_en
   always @(posedge rd_clk) begin
      if (fl_req) begin
         mem_q.delete();
         sb_w.delete();
      end
      if (ld_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            w_v = 8'((int'(ld_start) + i) % 255);
            if (i == ld_bad_idx) w_v = ld_bad_val;
            mem_q.push_back(w_v);
            sb_w.push_back(w_v);
         end
      end else if (fifo_rd_en && mem_q.size() > 0) begin
         fifo_rd_data <= mem_q.pop_front();
      end
      fcnt <= mem_q.size();
   end

   always @(negedge rd_clk) begin
      if (mon_on) begin
         if (fifo_rd_en) check("no_underflow", empty, 0);
         if (rd_data_vld) begin
            if (sb_w.size() == 0) check("vld_unexpected", 1, 0);
            else check("rd_data", rd_data, sb_w.pop_front());
         end
         if (burst_done) begin
            if (sb_len.size() == 0) begin
               check("burst_done_unexpected", 1, 0);
            end else begin
               check("burst_len", 32'(burst_len), sb_len.pop_front());
               check("burst_cnt", 32'(burst_cnt), sb_cnt.pop_front());
            end
         end
      end
   end

   task automatic chk_zero(input string t);
      check({t, "_rd_en"}, fifo_rd_en, 0);
      check({t, "_vld"}, rd_data_vld, 0);
      check({t, "_done"}, burst_done, 0);
      check({t, "_len"}, 32'(burst_len), 0);
      check({t, "_bcnt"}, 32'(burst_cnt), 0);
      check({t, "_err"}, err, 0);
      check({t, "_ecnt"}, 32'(err_cnt), 0);
   endtask

   task automatic load(input logic [7:0] s, input int bi,
                       input logic [7:0] bv, input logic fl);
      @(negedge rd_clk);
      ld_start   = s;
      ld_bad_idx = bi;
      ld_bad_val = bv;
      fl_req     = fl;
      ld_req     = 1'b1;
      @(posedge rd_clk);
      #1;
      ld_req = 1'b0;
      fl_req = 1'b0;
   endtask

   task automatic wait_rd(output int lat);
      lat = 0;
      while (!fifo_rd_en && lat < 20) begin
         @(posedge rd_clk);
         #1;
         lat++;
      end
   endtask

   task automatic finish_burst(output int nrd, output int ndone);
      nrd   = 0;
      ndone = 0;
      while (fifo_rd_en && nrd < 1000) begin
         nrd++;
         @(posedge rd_clk);
         #1;
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge rd_clk);
         #1;
         if (burst_done) ndone++;
      end
   endtask

   task automatic run_burst(input logic [7:0] s, input int cnt_exp);
      int lat, nrd, ndone;
      sb_len.push_back(DEPTH);
      sb_cnt.push_back(cnt_exp);
      load(s, -1, 8'd0, 1'b0);
      wait_rd(lat);
      check("burst_latency", lat, 3);
      finish_burst(nrd, ndone);
      check("burst_reads", nrd, DEPTH);
      check("burst_done_pulses", ndone, 1);
   endtask

   task automatic do_reset();
      @(negedge rd_clk);
      rst_n = 1'b0;
      #1;
      chk_zero("reset");
      fl_req = 1'b1;
      @(posedge rd_clk);
      #1;
      fl_req = 1'b0;
      sb_len.delete();
      sb_cnt.delete();
      @(negedge rd_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nrd, ndone, nen;
      repeat (3) @(posedge rd_clk);
      #1;
      chk_zero("por");
      @(negedge rd_clk);
      rst_n  = 1'b1;
      mon_on = 1'b1;

      // clean burst 0..254,0
      run_burst(8'd0, 1);
      check("t1_bcnt", 32'(burst_cnt), 1);
      check("t1_len", 32'(burst_len), 256);
      check("t1_err", err, 0);

      // word 5 corrupted to 9
      sb_len.push_back(DEPTH);
      sb_cnt.push_back(2);
      load(8'd0, 5, 8'd9, 1'b0);
      wait_rd(lat);
      check("t2_latency", lat, 3);
      repeat (6) begin
         @(posedge rd_clk);
         #1;
      end
      check("t2_bad_vld", rd_data_vld, 1);
      check("t2_bad_data", rd_data, 9);
      check("t2_err_before", err, 0);
      @(posedge rd_clk);
      #1;
      check("t2_err_set", err, 1);
      check("t2_ecnt_set", 32'(err_cnt), 1);
      finish_burst(nrd, ndone);
      check("t2_reads", nrd, 249);
      check("t2_done", ndone, 1);
      check("t2_ecnt_end", 32'(err_cnt), 1);
      check("t2_bcnt", 32'(burst_cnt), 2);

      // back-to-back clean bursts
      do_reset();
      run_burst(8'd0, 1);
      run_burst(8'd0, 2);
      check("t3_bcnt", 32'(burst_cnt), 2);
      check("t3_err", err, 0);
      check("t3_ecnt", 32'(err_cnt), 0);

      // second burst offset by 7
      do_reset();
      run_burst(8'd0, 1);
      run_burst(8'd7, 2);
      check("t4_ecnt", 32'(err_cnt), 256);
      check("t4_err", err, 1);
      check("t4_bcnt", 32'(burst_cnt), 2);

      // FIFO reset mid-burst after 100 reads
      load(8'd0, -1, 8'd0, 1'b0);
      wait_rd(lat);
      check("t5_latency", lat, 3);
      repeat (99) begin
         @(posedge rd_clk);
         #1;
      end
      check("t5_reading", fifo_rd_en, 1);
      @(posedge rd_clk);
      #1;
      rd_rst_busy = 1'b1;
      #1;
      check("t5_rd_en_drop", fifo_rd_en, 0);
      nen   = 0;
      ndone = 0;
      repeat (4) begin
         @(posedge rd_clk);
         #1;
         nen   += int'(fifo_rd_en);
         ndone += int'(burst_done);
      end
      rd_rst_busy = 1'b0;
      repeat (10) begin
         @(posedge rd_clk);
         #1;
         nen   += int'(fifo_rd_en);
         ndone += int'(burst_done);
      end
      check("t5_no_reads", nen, 0);
      check("t5_no_done", ndone, 0);
      check("t5_bcnt", 32'(burst_cnt), 2);
      check("t5_left", fcnt, 156);

      // async reset mid-burst, restart with full held
      load(8'd0, -1, 8'd0, 1'b1);
      wait_rd(lat);
      repeat (50) begin
         @(posedge rd_clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk_zero("t6_async");
      sb_len.push_back(DEPTH);
      sb_cnt.push_back(1);
      load(8'd0, -1, 8'd0, 1'b1);
      check("t6_full_held", full, 1);
      @(negedge rd_clk);
      rst_n = 1'b1;
      wait_rd(lat);
      check("t6_latency", lat, 3);
      finish_burst(nrd, ndone);
      check("t6_reads", nrd, 256);
      check("t6_done", ndone, 1);
      check("t6_err", err, 0);
      check("t6_bcnt", 32'(burst_cnt), 1);

      // full forced while the FIFO is empty
      sb_len.push_back(0);
      sb_cnt.push_back(2);
      @(negedge rd_clk);
      force_full = 1'b1;
      @(negedge rd_clk);
      force_full = 1'b0;
      nen   = 0;
      ndone = 0;
      repeat (12) begin
         @(posedge rd_clk);
         #1;
         nen   += int'(fifo_rd_en);
         ndone += int'(burst_done);
      end
      check("t7_no_reads", nen, 0);
      check("t7_done", ndone, 1);
      check("t7_len", 32'(burst_len), 0);
      check("t7_bcnt", 32'(burst_cnt), 2);

      check("sb_words_left", sb_w.size(), 0);
      check("sb_bursts_left", sb_len.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
